// File: rtl/stream_out_fifo_if.sv
// stream_out_fifo_if: valid/ready/data stream bundle used on both sides of the elastic buffer.
interface stream_out_fifo_if #(parameter int WIDTH = 128);
  logic             valid;
  logic             rdy;
  logic [WIDTH-1:0] data;
  modport master (output valid, data, input rdy);
  modport slave (input valid, data, output rdy);
endinterface

// File: rtl/stream_out_fifo.sv
// stream_out_fifo: first-word-fall-through elastic buffer from a stream producer to the OUT port.
// Defining STREAM_FIFO_STATS_EN builds the popped-beat and stall counters; otherwise they read 0.
module stream_out_fifo #(
  parameter  int WIDTH = 128,
  parameter  int DEPTH = 16,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic                     clk,
  input  logic                     rst,
  stream_out_fifo_if.slave         src,
  stream_out_fifo_if.master        dst,
  output logic [AW:0]              level,
  output logic [31:0]              beat_cnt,
  output logic [31:0]              stall_cnt
);
  localparam logic [AW:0] full_lvl = (AW+1)'(DEPTH);
  localparam logic [AW:0] one_lvl  = (AW+1)'(1);
  localparam logic [AW-1:0] one_ptr = AW'(1);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic             push, pop;
  // Ready comes from registered level only, so out_rdy never ripples back to the producer.
  assign src.rdy   = ~rst & (level != full_lvl);
  assign dst.valid = level != '0;
  assign dst.data  = mem[rd_ptr];
  assign push      = src.valid & src.rdy;
  assign pop       = dst.valid & dst.rdy;
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= src.data;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + one_ptr;
      if (pop) rd_ptr <= rd_ptr + one_ptr;
      level <= (push == pop) ? level : push ? level + one_lvl : level - one_lvl;
    end
`ifdef STREAM_FIFO_STATS_EN
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      beat_cnt  <= '0;
      stall_cnt <= '0;
    end else begin
      if (pop) beat_cnt <= beat_cnt + 32'd1;
      if (dst.valid & ~dst.rdy) stall_cnt <= stall_cnt + 32'd1;
    end
`else
  assign beat_cnt  = '0;
  assign stall_cnt = '0;
`endif
endmodule

// File: tb/tb_stream_out_fifo.sv
// tb_stream_out_fifo: directed stimulus with a queue scoreboard checking every popped beat.
module tb_stream_out_fifo;
  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [4:0]   level;
  logic [31:0]  beat_cnt, stall_cnt;
  logic [127:0] exp_q[$];
  int           n_chk = 0;
  int           n_fail = 0;

  stream_out_fifo_if #(.WIDTH(128)) src_if ();
  stream_out_fifo_if #(.WIDTH(128)) dst_if ();

  stream_out_fifo dut (
    .clk(clk), .rst(rst), .src(src_if.slave), .dst(dst_if.master),
    .level(level), .beat_cnt(beat_cnt), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    src_if.valid = 1'b0;
    dst_if.rdy = 1'b0;
    cyc(2);
    exp_q.delete();
    rst = 1'b0;
    #1;
  endtask

  // Record every accepted beat; the handshake is stable at the falling edge.
  always @(negedge clk)
    if (!rst && src_if.valid && src_if.rdy) exp_q.push_back(src_if.data);

  // Compare every beat the consumer takes against the oldest recorded beat.
  always @(negedge clk)
    if (!rst && dst_if.valid && dst_if.rdy) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL pop_empty: got %0h expected no beat", dst_if.data);
      end else chk("out_data", dst_if.data, exp_q.pop_front());
    end

  initial begin
    logic [127:0] sum;
    logic         r;
    int           sent, cyc_n;
    src_if.valid = 1'b0;
    src_if.data  = '0;
    dst_if.rdy   = 1'b0;
    #2;
    chk("rst_in_rdy", src_if.rdy, 0);
    chk("rst_level", level, 0);
    chk("rst_out_valid", dst_if.valid, 0);
    do_reset();
    chk("post_rst_in_rdy", src_if.rdy, 1);
    // 1: single beat latency
    dst_if.rdy = 1'b1;
    src_if.valid = 1'b1;
    src_if.data = 128'h42424242_deadbeef_00000001_00000001;
    chk("t1_no_bypass", dst_if.valid, 0);
    cyc(1);
    src_if.valid = 1'b0;
    chk("t1_out_valid", dst_if.valid, 1);
    chk("t1_level1", level, 1);
    cyc(1);
    chk("t1_level0", level, 0);
    chk("t1_empty", dst_if.valid, 0);
    // 2: fill to full, then drain
    dst_if.rdy = 1'b0;
    src_if.valid = 1'b1;
    for (int i = 0; i < 16; i++) begin
      src_if.data = 128'(i + 1);
      cyc(1);
    end
    chk("t2_level16", level, 16);
    chk("t2_full_rdy", src_if.rdy, 0);
    src_if.data = 128'd17;
    cyc(1);
    chk("t2_level_hold", level, 16);
    dst_if.rdy = 1'b1;
    #1 chk("t2_rdy_indep", src_if.rdy, 0);
    cyc(1);
    chk("t2_pop_at_full", level, 15);
    chk("t2_slot_freed", src_if.rdy, 1);
    src_if.valid = 1'b0;
    cyc(15);
    chk("t2_drained", level, 0);
    chk("t2_out_valid0", dst_if.valid, 0);
    // 3: steady state at level 8 with wrapping pointers
    dst_if.rdy = 1'b0;
    src_if.valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      src_if.data = 128'(100 + i);
      cyc(1);
    end
    chk("t3_level8", level, 8);
    dst_if.rdy = 1'b1;
    for (int i = 0; i < 100; i++) begin
      src_if.data = 128'(200 + i);
      cyc(1);
      chk("t3_level_steady", level, 8);
    end
    src_if.valid = 1'b0;
    cyc(8);
    chk("t3_drained", level, 0);
    // 4: random handshakes carrying a running sum
    sum = '0;
    sent = 0;
    cyc_n = 0;
    while (sent < 10000 && cyc_n < 60000) begin
      src_if.valid = 1'($urandom_range(1));
      dst_if.rdy = 1'b0;
      src_if.data = sum + 128'(sent + 1);
      r = src_if.rdy;
      #1 dst_if.rdy = 1'($urandom_range(1));
      #1 if (src_if.rdy !== r) chk("t4_in_rdy_comb", src_if.rdy, r);
      if (src_if.valid && src_if.rdy) begin
        sent++;
        sum = src_if.data;
      end
      cyc(1);
      cyc_n++;
    end
    chk("t4_beats_sent", 128'(sent), 128'd10000);
    src_if.valid = 1'b0;
    dst_if.rdy = 1'b1;
    cyc(20);
    chk("t4_drained", level, 0);
    chk("t4_sb_empty", 128'(exp_q.size()), 0);
    // 5: reset mid-operation
    dst_if.rdy = 1'b0;
    src_if.valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      src_if.data = 128'(300 + i);
      cyc(1);
    end
    src_if.valid = 1'b0;
    chk("t5_level5", level, 5);
    #2 rst = 1'b1;
    #1;
    chk("t5_async_level", level, 0);
    chk("t5_async_valid", dst_if.valid, 0);
    chk("t5_rst_in_rdy", src_if.rdy, 0);
    exp_q.delete();
    cyc(2);
    chk("t5_hold_in_rdy", src_if.rdy, 0);
    rst = 1'b0;
    #1 chk("t5_release_rdy", src_if.rdy, 1);
    dst_if.rdy = 1'b1;
    src_if.valid = 1'b1;
    src_if.data = 128'h555;
    cyc(1);
    src_if.valid = 1'b0;
    chk("t5_first_post", dst_if.data, 128'h555);
    cyc(2);
    chk("t5_level0", level, 0);
    // 6: statistics counters
    do_reset();
    chk("t6_rst_beat", beat_cnt, 0);
    chk("t6_rst_stall", stall_cnt, 0);
    src_if.valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      src_if.data = 128'(32'h600 + i);
      cyc(1);
    end
    src_if.valid = 1'b0;
    cyc(2);
    dst_if.rdy = 1'b1;
    cyc(3);
    dst_if.rdy = 1'b0;
    cyc(1);
    chk("t6_level0", level, 0);
`ifdef STREAM_FIFO_STATS_EN
    chk("t6_beat_cnt", beat_cnt, 3);
    chk("t6_stall_cnt", stall_cnt, 4);
`else
    chk("t6_beat_cnt", beat_cnt, 0);
    chk("t6_stall_cnt", stall_cnt, 0);
`endif
    chk("final_sb_empty", 128'(exp_q.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
